// File: rtl/pkt_resizer_spp.sv
// Re-frames a sample stream into packets of spp samples (spp=0: pass i_tlast through); 1-cycle latency, 2-entry skid.
// Optional PKT_RESIZER_HONOR_TLAST_EN: an input tlast also closes the current output packet early.
module pkt_resizer_spp #(
  parameter int WIDTH   = 32,
  parameter int MAX_SPP = 65535,
  localparam int CW     = $clog2(MAX_SPP + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CW-1:0]    spp,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  logic [CW-1:0]    spp_reg_q, spp_active_q, spp_active_d;
  logic [CW-1:0]    cnt_q, cnt_d, len;
  logic             out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic             skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             in_rdy_q;
  logic             accept, drain, first, beat_last;

  assign accept   = i_tvalid & in_rdy_q;
  assign drain    = o_tready & out_vld_q;
  assign first    = (cnt_q == CW'(1));
  assign len      = first ? spp_reg_q : spp_active_q;
  assign i_tready = in_rdy_q;
  assign o_tvalid = out_vld_q;
  assign o_tdata  = out_dat_q;
  assign o_tlast  = out_last_q;

  // Length is latched on the first beat so a new spp only applies at a packet boundary.
  always_comb begin
    beat_last    = 1'b0;
    cnt_d        = cnt_q;
    spp_active_d = spp_active_q;
    if (accept) begin
      if (first) spp_active_d = spp_reg_q;
      if (len == '0) begin
        beat_last = i_tlast;
        cnt_d     = CW'(1);
      end else begin
        beat_last = (cnt_q >= len) || (cnt_q == CW'(MAX_SPP));
`ifdef PKT_RESIZER_HONOR_TLAST_EN
        if (i_tlast) beat_last = 1'b1;
`endif
        cnt_d = beat_last ? CW'(1) : cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    out_vld_d   = out_vld_q;
    out_dat_d   = out_dat_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_dat_d  = skid_dat_q;
    skid_last_d = skid_last_q;
    if (!out_vld_q || drain) begin
      // in_rdy_q is low whenever the skid holds a beat, so skid refill and accept never coincide
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        out_last_d = skid_last_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_vld_d  = 1'b1;
        out_dat_d  = i_tdata;
        out_last_d = beat_last;
      end else begin
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_dat_d  = i_tdata;
      skid_last_d = beat_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spp_reg_q    <= CW'(1);
      spp_active_q <= CW'(1);
      cnt_q        <= CW'(1);
      out_vld_q    <= 1'b0;
      out_dat_q    <= '0;
      out_last_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_dat_q   <= '0;
      skid_last_q  <= 1'b0;
      in_rdy_q     <= 1'b0;
    end else begin
      spp_reg_q    <= spp;
      spp_active_q <= spp_active_d;
      cnt_q        <= cnt_d;
      out_vld_q    <= out_vld_d;
      out_dat_q    <= out_dat_d;
      out_last_q   <= out_last_d;
      skid_vld_q   <= skid_vld_d;
      skid_dat_q   <= skid_dat_d;
      skid_last_q  <= skid_last_d;
      in_rdy_q     <= ~skid_vld_d;
    end
  end

endmodule

// File: tb/tb_pkt_resizer_spp.sv
// Randomized bench for pkt_resizer_spp; expected framing comes from a packet-position model.
module tb_pkt_resizer_spp;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] spp;
  logic [31:0] i_tdata;
  logic        i_tlast, i_tvalid, i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast, o_tvalid, o_tready;

  pkt_resizer_spp #(.WIDTH(32), .MAX_SPP(65535)) dut (
    .clk(clk), .reset(reset), .spp(spp),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int n_checks = 0, n_pass = 0;
  int rdy_mode = 0;
  int cyc = 0, occ = 0, pos = 0, lock = 0;
  int rdy_err = 0, stab_err = 0, tl_err = 0, rdy_low = 0;
  int spp_prev = 1;
  bit rst_prev = 1, prev_stall = 0, prev_l;
  logic [31:0] prev_d;

  // Model: a beat's packet position and the length locked at packet start decide tlast.
  always @(negedge clk) begin
    bit acc, drn, l;
    cyc++;
    if (reset) begin
      pos = 0; occ = 0; prev_stall = 0; rst_prev = 1;
    end else begin
      if (!rst_prev && (i_tready !== (occ < 2))) rdy_err++;
      if (!i_tready) rdy_low++;
      if (o_tlast && !o_tvalid) tl_err++;
      if (prev_stall && (o_tvalid !== 1'b1 || o_tdata !== prev_d || o_tlast !== prev_l)) stab_err++;
      acc = i_tvalid && i_tready;
      drn = o_tvalid && o_tready;
      if (drn) obs_q.push_back('{o_tdata, o_tlast, cyc});
      if (acc) begin
        if (pos == 0) lock = spp_prev;
        if (lock == 0) l = i_tlast;
        else begin
          pos++;
          l = (pos == lock);
`ifdef PKT_RESIZER_HONOR_TLAST_EN
          if (i_tlast) l = 1;
`endif
          if (l) pos = 0;
        end
        exp_q.push_back('{i_tdata, l, cyc});
      end
      occ += int'(acc) - int'(drn);
      prev_stall = o_tvalid && !o_tready;
      prev_d = o_tdata; prev_l = o_tlast;
      rst_prev = 0;
    end
    spp_prev = reset ? 1 : int'(spp);
  end

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       o_tready = 1'b1;
        1:       o_tready = ~o_tready;
        default: o_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int t = 0;
    bit acc;
    i_tvalid = 1'b1; i_tdata = d; i_tlast = l;
    forever begin
      @(negedge clk); acc = i_tready;
      @(posedge clk); #1;
      if (acc) break;
      if (++t > 200) begin
        n_checks++;
        $display("FAIL send_timeout: i_tready stayed %b, required 1", i_tready);
        break;
      end
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    rdy_mode = 0;
    while (obs_q.size() < exp_q.size() || o_tvalid) begin
      @(negedge clk);
      if (++t > 500) begin
        n_checks++;
        $display("FAIL drain_timeout: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic start(input int s);
    spp = 16'(s);
    idle(3);
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0; spp = 16'd4;
    #1;
    n_checks++;
    if ({o_tvalid, o_tlast, o_tdata, i_tready} !== 35'd0)
      $display("FAIL reset_outputs: got vld=%b last=%b data=%h rdy=%b, required all 0",
               o_tvalid, o_tlast, o_tdata, i_tready);
    else n_pass++;
    idle(2);
    reset = 1'b0;
    n_checks++;
    if (i_tready !== 1'b0) $display("FAIL rdy_before_edge: got %b, required 0", i_tready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (i_tready !== 1'b1) $display("FAIL rdy_after_edge: got %b, required 1", i_tready);
    else n_pass++;
  endtask

  task automatic test_basic();
    start(4);
    for (int i = 0; i < 12; i++) send($urandom, 1'b0);
    wait_drain();
    n_checks++;
    if (obs_q.size() != 12 || exp_q.size() != 12)
      $display("FAIL basic_count: got %0d out/%0d in, required 12", obs_q.size(), exp_q.size());
    else begin
      n_pass++;
      n_checks++;
      if (exp_q[11].cyc - exp_q[0].cyc != 11)
        $display("FAIL basic_input_bubbles: span %0d cycles, required 11", exp_q[11].cyc - exp_q[0].cyc);
      else n_pass++;
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (obs_q[i].d !== exp_q[i].d || obs_q[i].l !== (i % 4 == 3) || obs_q[i].cyc != exp_q[i].cyc + 1)
          $display("FAIL basic_beat%0d: got d=%h l=%b lat=%0d, required d=%h l=%b lat=1", i,
                   obs_q[i].d, obs_q[i].l, obs_q[i].cyc - exp_q[i].cyc, exp_q[i].d, (i % 4 == 3));
        else n_pass++;
      end
    end
  endtask

  task automatic test_toggle();
    int low0;
    start(3);
    low0 = rdy_low;
    rdy_mode = 1;
    for (int i = 0; i < 9; i++) send(32'(i), 1'b0);
    wait_drain();
    n_checks++;
    if (obs_q.size() != 9) $display("FAIL toggle_count: got %0d, required 9", obs_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (obs_q[i].d !== 32'(i) || obs_q[i].l !== (i % 3 == 2))
          $display("FAIL toggle_beat%0d: got d=%0d l=%b, required d=%0d l=%b",
                   i, obs_q[i].d, obs_q[i].l, i, (i % 3 == 2));
        else n_pass++;
      end
    end
    n_checks++;
    if (rdy_low == low0) $display("FAIL toggle_backpressure: i_tready never dropped, required a drop");
    else n_pass++;
    n_checks++;
    if (rdy_err != 0 || stab_err != 0 || tl_err != 0)
      $display("FAIL toggle_protocol: rdy_err=%0d stab_err=%0d tl_err=%0d, required 0/0/0",
               rdy_err, stab_err, tl_err);
    else n_pass++;
  endtask

  task automatic test_spp_change();
    start(5);
    for (int i = 0; i < 3; i++) send($urandom, 1'b0);
    spp = 16'd2;
    for (int i = 0; i < 8; i++) send($urandom, 1'b0);
    wait_drain();
    n_checks++;
    if (obs_q.size() != 11) $display("FAIL change_count: got %0d, required 11", obs_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 11; i++) begin
        n_checks++;
        if (obs_q[i].d !== exp_q[i].d || obs_q[i].l !== (i == 4 || i == 6 || i == 8 || i == 10))
          $display("FAIL change_beat%0d: got d=%h l=%b, required d=%h l=%b", i,
                   obs_q[i].d, obs_q[i].l, exp_q[i].d, (i == 4 || i == 6 || i == 8 || i == 10));
        else n_pass++;
      end
    end
  endtask

  task automatic test_passthrough();
    start(0);
    for (int i = 0; i < 10; i++) send($urandom, (i == 2 || i == 9));
    wait_drain();
    n_checks++;
    if (obs_q.size() != 10) $display("FAIL pass_count: got %0d, required 10", obs_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (obs_q[i].d !== exp_q[i].d || obs_q[i].l !== (i == 2 || i == 9))
          $display("FAIL pass_beat%0d: got d=%h l=%b, required d=%h l=%b", i,
                   obs_q[i].d, obs_q[i].l, exp_q[i].d, (i == 2 || i == 9));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    start(8);
    for (int i = 0; i < 5; i++) send($urandom, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (o_tvalid !== 1'b0 || o_tlast !== 1'b0 || i_tready !== 1'b0)
      $display("FAIL mid_reset_async: got vld=%b last=%b rdy=%b, required 0/0/0", o_tvalid, o_tlast, i_tready);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 8; i++) send($urandom, 1'b0);
    wait_drain();
    n_checks++;
    if (obs_q.size() != 8) $display("FAIL mid_count: got %0d, required 8", obs_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (obs_q[i].d !== exp_q[i].d || obs_q[i].l !== (i == 7))
          $display("FAIL mid_beat%0d: got d=%h l=%b, required d=%h l=%b", i,
                   obs_q[i].d, obs_q[i].l, exp_q[i].d, (i == 7));
        else n_pass++;
      end
    end
  endtask

`ifdef PKT_RESIZER_HONOR_TLAST_EN
  task automatic test_honor_tlast();
    start(10);
    for (int i = 0; i < 16; i++) send($urandom, (i == 5));
    wait_drain();
    n_checks++;
    if (obs_q.size() != 16) $display("FAIL honor_count: got %0d, required 16", obs_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (obs_q[i].d !== exp_q[i].d || obs_q[i].l !== (i == 5 || i == 15))
          $display("FAIL honor_beat%0d: got d=%h l=%b, required d=%h l=%b", i,
                   obs_q[i].d, obs_q[i].l, exp_q[i].d, (i == 5 || i == 15));
        else n_pass++;
      end
    end
  endtask
`endif

  task automatic test_random();
    int choices[6] = '{0, 1, 2, 3, 4, 7};
    int bad = 0;
    start(3);
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) spp = 16'(choices[$urandom_range(0, 5)]);
      send($urandom, 1'($urandom_range(0, 3) == 0));
      rdy_mode = 2;
      idle($urandom_range(0, 1));
    end
    wait_drain();
    n_checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 400)
      $display("FAIL random_count: got %0d out/%0d in, required 400", obs_q.size(), exp_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 400; i++)
        if (obs_q[i].d !== exp_q[i].d || obs_q[i].l !== exp_q[i].l) begin
          if (bad == 0)
            $display("FAIL random_beat%0d: got d=%h l=%b, required d=%h l=%b", i,
                     obs_q[i].d, obs_q[i].l, exp_q[i].d, exp_q[i].l);
          bad++;
        end
      n_checks++;
      if (bad != 0) $display("FAIL random_stream: %0d beats differ, required 0", bad);
      else n_pass++;
    end
    n_checks++;
    if (rdy_err != 0 || stab_err != 0 || tl_err != 0)
      $display("FAIL random_protocol: rdy_err=%0d stab_err=%0d tl_err=%0d, required 0/0/0",
               rdy_err, stab_err, tl_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_spp_change();
    test_passthrough();
    test_reset_mid();
`ifdef PKT_RESIZER_HONOR_TLAST_EN
    test_honor_tlast();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
